clk_reset_sequencer: RTL and testbench
======================================

# clk_reset_sequencer

Sequencer for the board's PLL-generated clock tree and the resets below it. It runs on the raw reference clock and drives the PLL reset. It waits for a filtered PLL lock, then releases a parametrised number of downstream reset lines one at a time with fixed spacing. If lock is lost or never arrives, it re-runs the whole sequence. It sits in the top-level wrapper between the PLL and the core, replacing the tied-off PLL reset with retry, lock filtering and staggered release.

## Interface
- NUM_RESETS, 5: number of downstream reset outputs; range 1..16.
- PLL_RESET_CYCLES, 16: length of the pll_reset pulse in clk cycles; must be ≥ 1.
- LOCK_TIMEOUT, 250000: cycles allowed in WAIT_LOCK before a retry (10 ms at 25 MHz); must be ≥ 2.
- LOCK_FILTER, 64: consecutive cycles synchronised lock must stay high before release; must be ≥ 1.
- STAGGER_CYCLES, 256: spacing between successive reset releases; must be ≥ 1.
- clk  in  1  reference clock (PLL refclk domain).
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock, asynchronous to clk; passes through a 2-FF synchroniser to give locked_s.
- pll_reset  out  1  PLL reset, active high.
- rst_out  out  NUM_RESETS  downstream resets, active high; bit 0 is released first.
- ready  out  1  high only in RUN.
- retry_count  out  8  number of lock-timeout retries; saturates at 255.
- lock_loss_count  out  8  number of lock losses in FILTER, RELEASE or RUN; saturates at 255.

## Operation
- While rst is high: state = RESET_PLL, pll_reset = 1, rst_out = all ones, ready = 0, both counters = 0, synchroniser = 0, cycle timer = 0, release index = 0.
- All outputs are registered. Each state entry clears the cycle timer.
- RESET_PLL
  - pll_reset = 1, rst_out = all ones.
  - After PLL_RESET_CYCLES cycles: go to WAIT_LOCK, pll_reset = 0.
- WAIT_LOCK
  - locked_s = 1: go to FILTER.
  - Otherwise, if the timer reaches LOCK_TIMEOUT−1: go to RESET_PLL and increment retry_count (saturating).
- FILTER
  - locked_s = 0: go to WAIT_LOCK and increment lock_loss_count. The WAIT_LOCK timer restarts from 0.
  - locked_s = 1 for LOCK_FILTER consecutive cycles: go to RELEASE with index 0.
- RELEASE
  - Every STAGGER_CYCLES cycles, clear rst_out[index] and increment index.
  - The cycle that clears bit NUM_RESETS−1 also moves to RUN and sets ready = 1.
  - Bits already released stay low.
- RUN
  - Hold outputs steady.
- Lock loss during RELEASE or RUN (locked_s = 0)
  - On the next edge: state = RESET_PLL, pll_reset = 1, rst_out = all ones, ready = 0.
  - Increment lock_loss_count (saturating).
- Simultaneous events in WAIT_LOCK: if locked_s rises on the timeout cycle, lock wins. Go to FILTER; no retry is counted.
- Counter saturation: at 255, further events leave the value at 255. No wrap.
- Width rule: the cycle timer is wide enough for max(LOCK_TIMEOUT, PLL_RESET_CYCLES, LOCK_FILTER, STAGGER_CYCLES).
- Reset mid-sequence: asserting rst in any state returns every output to its reset value immediately, without waiting for a clock edge.

## Timing
- pll_locked to locked_s: 2 cycles. Total lock-to-FILTER-entry latency: 3 cycles.
- pll_reset stays high through rst and falls at the PLL_RESET_CYCLES-th rising edge after rst deasserts.
- FILTER entry to rst_out[0] low: LOCK_FILTER + STAGGER_CYCLES cycles. rst_out[k] falls (k+1)·STAGGER_CYCLES cycles after RELEASE entry.
- ready rises on the same edge that rst_out[NUM_RESETS−1] falls.
- locked_s low to pll_reset high / rst_out all ones / ready low: 1 edge.
- Retry period with no lock ever: PLL_RESET_CYCLES + LOCK_TIMEOUT cycles per retry_count increment.

## Test plan
Bench parameters: NUM_RESETS=3, PLL_RESET_CYCLES=4, LOCK_TIMEOUT=100, LOCK_FILTER=8, STAGGER_CYCLES=10.
- Clean start: release rst, raise pll_locked 20 cycles later and hold it.
  - pll_reset falls at edge 4.
  - rst_out goes 3'b111 → 3'b110 → 3'b100 → 3'b000 at 10-cycle spacing.
  - ready = 1 with rst_out = 0.
  - Both counters = 0.
- No lock: hold pll_locked = 0 for 1000 cycles.
  - pll_reset pulses every 104 cycles.
  - retry_count = 9; rst_out stays 3'b111.
- Glitchy lock: pulse pll_locked high for 5 cycles, then low, then hold high.
  - FILTER aborts and lock_loss_count = 1.
  - Second FILTER completes; ready = 1 after a further 8 + 30 cycles.
- Lock loss in RUN: drop pll_locked for 1 cycle.
  - Within 3 edges: pll_reset = 1, rst_out = 3'b111, ready = 0, lock_loss_count = 1.
  - Full sequence repeats.
- Lock loss mid-RELEASE: drop pll_locked after rst_out = 3'b110.
  - All bits reassert; the sequence restarts from RESET_PLL.
- Async reset in RUN: assert rst between clock edges.
  - Outputs return to reset values before the next edge.
  - Counters clear to 0.
- Saturation: force 300 timeouts.
  - retry_count holds at 255.

Source files
------------

// File: rtl/clk_reset_sequencer_if.sv
// clk_reset_sequencer_if: PLL lock input plus reset, ready and status outputs of the sequencer
interface clk_reset_sequencer_if #(
    parameter int NUM_RESETS = 5
);
    logic                  pll_locked;
    logic                  pll_reset;
    logic [NUM_RESETS-1:0] rst_out;
    logic                  ready;
    logic [7:0]            retry_count;
    logic [7:0]            lock_loss_count;

    modport master (
        input  pll_locked,
        output pll_reset, rst_out, ready, retry_count, lock_loss_count
    );

    modport slave (
        output pll_locked,
        input  pll_reset, rst_out, ready, retry_count, lock_loss_count
    );
endinterface

// File: rtl/clk_reset_sequencer.sv
// clk_reset_sequencer: PLL reset with retry, filtered lock and staggered downstream reset release
module clk_reset_sequencer #(
    parameter int NUM_RESETS       = 5,
    parameter int PLL_RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 250000,
    parameter int LOCK_FILTER      = 64,
    parameter int STAGGER_CYCLES   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    clk_reset_sequencer_if.master  bus
);
    localparam int M1   = LOCK_TIMEOUT > PLL_RESET_CYCLES ? LOCK_TIMEOUT : PLL_RESET_CYCLES;
    localparam int M2   = LOCK_FILTER > STAGGER_CYCLES ? LOCK_FILTER : STAGGER_CYCLES;
    localparam int MAXC = M1 > M2 ? M1 : M2;
    localparam int TW   = $clog2(MAXC + 1);
    localparam int IW   = NUM_RESETS > 1 ? $clog2(NUM_RESETS) : 1;

    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, FILTER, RELEASE, RUN} state_t;

    state_t                state;
    logic [1:0]            sync;
    logic                  locked_s;
    logic [TW-1:0]         timer;
    logic [IW-1:0]         idx;
    logic                  pll_reset;
    logic [NUM_RESETS-1:0] rst_out;
    logic                  ready;
    logic [7:0]            retry_count;
    logic [7:0]            lock_loss_count;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return v + {7'd0, v != 8'hff};
    endfunction

    assign locked_s            = sync[1];
    assign bus.pll_reset       = pll_reset;
    assign bus.rst_out         = rst_out;
    assign bus.ready           = ready;
    assign bus.retry_count     = retry_count;
    assign bus.lock_loss_count = lock_loss_count;

    // Two-stage synchroniser bringing the asynchronous PLL lock into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], bus.pll_locked};
    end

    // Sequencer FSM: every state entry clears the timer; losing lock after FILTER restarts from the PLL reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RESET_PLL;
            pll_reset       <= 1'b1;
            rst_out         <= '1;
            ready           <= 1'b0;
            retry_count     <= '0;
            lock_loss_count <= '0;
            timer           <= '0;
            idx             <= '0;
        end else begin
            case (state)
                RESET_PLL:
                    if (timer == TW'(PLL_RESET_CYCLES - 1)) begin
                        state     <= WAIT_LOCK;
                        pll_reset <= 1'b0;
                        timer     <= '0;
                    end else timer <= timer + 1'b1;
                WAIT_LOCK:
                    if (locked_s) begin
                        state <= FILTER;
                        timer <= '0;
                    end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                        state       <= RESET_PLL;
                        pll_reset   <= 1'b1;
                        timer       <= '0;
                        retry_count <= sat_inc(retry_count);
                    end else timer <= timer + 1'b1;
                FILTER:
                    if (!locked_s) begin
                        state           <= WAIT_LOCK;
                        timer           <= '0;
                        lock_loss_count <= sat_inc(lock_loss_count);
                    end else if (timer == TW'(LOCK_FILTER - 1)) begin
                        state <= RELEASE;
                        timer <= '0;
                        idx   <= '0;
                    end else timer <= timer + 1'b1;
                RELEASE, RUN:
                    if (!locked_s) begin
                        state           <= RESET_PLL;
                        pll_reset       <= 1'b1;
                        rst_out         <= '1;
                        ready           <= 1'b0;
                        timer           <= '0;
                        lock_loss_count <= sat_inc(lock_loss_count);
                    end else if (state == RELEASE) begin
                        if (timer == TW'(STAGGER_CYCLES - 1)) begin
                            rst_out[idx] <= 1'b0;
                            idx          <= idx + 1'b1;
                            timer        <= '0;
                            if (idx == IW'(NUM_RESETS - 1)) begin
                                state <= RUN;
                                ready <= 1'b1;
                            end
                        end else timer <= timer + 1'b1;
                    end
                default: state <= RESET_PLL;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_reset_sequencer.sv
// tb_clk_reset_sequencer: vector table plus hand sequences for the clock/reset sequencer
module tb_clk_reset_sequencer;
    localparam int NR  = 3;
    localparam int PRC = 4;
    localparam int LT  = 100;
    localparam int LF  = 8;
    localparam int SC  = 10;

    typedef struct {
        string         name;
        logic          rst;
        logic          locked;
        int            cycles;
        logic          pll;
        logic [NR-1:0] rsto;
        logic          rdy;
        logic [7:0]    retry;
        logic [7:0]    loss;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t tab[$];
    vec_t exp_q[$];
    int   rise_q[$];

    clk_reset_sequencer_if #(.NUM_RESETS(NR)) bus ();

    clk_reset_sequencer #(
        .NUM_RESETS(NR), .PLL_RESET_CYCLES(PRC), .LOCK_TIMEOUT(LT),
        .LOCK_FILTER(LF), .STAGGER_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic l, input int c,
                                input logic p, input logic [NR-1:0] ro, input logic rd,
                                input logic [7:0] rc, input logic [7:0] lc);
        vec_t v;
        v.name = name; v.rst = r; v.locked = l; v.cycles = c;
        v.pll = p; v.rsto = ro; v.rdy = rd; v.retry = rc; v.loss = lc;
        return v;
    endfunction

    initial begin
        vec_t v;
        vec_t e;
        logic prev;
        bus.pll_locked = 1'b0;
        // Clean start: edges counted from rst release; lock raised after edge 20
        tab.push_back(mk("reset",      1, 0,  2, 1, 3'b111, 0, 0, 0));
        tab.push_back(mk("cs_e3",      0, 0,  3, 1, 3'b111, 0, 0, 0));
        tab.push_back(mk("cs_e4",      0, 0,  1, 0, 3'b111, 0, 0, 0));
        tab.push_back(mk("cs_e20",     0, 0, 16, 0, 3'b111, 0, 0, 0));
        tab.push_back(mk("cs_e40",     0, 1, 20, 0, 3'b111, 0, 0, 0));
        tab.push_back(mk("cs_e41",     0, 1,  1, 0, 3'b110, 0, 0, 0));
        tab.push_back(mk("cs_e50",     0, 1,  9, 0, 3'b110, 0, 0, 0));
        tab.push_back(mk("cs_e51",     0, 1,  1, 0, 3'b100, 0, 0, 0));
        tab.push_back(mk("cs_e60",     0, 1,  9, 0, 3'b100, 0, 0, 0));
        tab.push_back(mk("cs_e61",     0, 1,  1, 0, 3'b000, 1, 0, 0));
        tab.push_back(mk("cs_e81",     0, 1, 20, 0, 3'b000, 1, 0, 0));
        // Lock loss in RUN: one-cycle drop, seen at the third edge
        tab.push_back(mk("run_e82",    0, 0,  1, 0, 3'b000, 1, 0, 0));
        tab.push_back(mk("run_e83",    0, 1,  1, 0, 3'b000, 1, 0, 0));
        tab.push_back(mk("run_e84",    0, 1,  1, 1, 3'b111, 0, 0, 1));
        tab.push_back(mk("run_e87",    0, 1,  3, 1, 3'b111, 0, 0, 1));
        tab.push_back(mk("run_e88",    0, 1,  1, 0, 3'b111, 0, 0, 1));
        tab.push_back(mk("run_e106",   0, 1, 18, 0, 3'b111, 0, 0, 1));
        tab.push_back(mk("run_e107",   0, 1,  1, 0, 3'b110, 0, 0, 1));
        tab.push_back(mk("run_e127",   0, 1, 20, 0, 3'b000, 1, 0, 1));
        // Lock loss mid-RELEASE, lock already high while in reset
        tab.push_back(mk("mr_reset",   1, 1,  1, 1, 3'b111, 0, 0, 0));
        tab.push_back(mk("mr_e23",     0, 1, 23, 0, 3'b110, 0, 0, 0));
        tab.push_back(mk("mr_e25",     0, 0,  2, 0, 3'b110, 0, 0, 0));
        tab.push_back(mk("mr_e26",     0, 0,  1, 1, 3'b111, 0, 0, 1));
        tab.push_back(mk("mr_e30",     0, 0,  4, 0, 3'b111, 0, 0, 1));
        // Glitchy lock: 5-cycle pulse aborts FILTER, then steady lock
        tab.push_back(mk("gl_reset",   1, 0,  1, 1, 3'b111, 0, 0, 0));
        tab.push_back(mk("gl_e10",     0, 0, 10, 0, 3'b111, 0, 0, 0));
        tab.push_back(mk("gl_e15",     0, 1,  5, 0, 3'b111, 0, 0, 0));
        tab.push_back(mk("gl_e18",     0, 0,  3, 0, 3'b111, 0, 0, 1));
        tab.push_back(mk("gl_e58",     0, 1, 40, 0, 3'b100, 0, 0, 1));
        tab.push_back(mk("gl_e59",     0, 1,  1, 0, 3'b000, 1, 0, 1));

        @(posedge clk); #1;
        for (int i = 0; i < tab.size(); i++) begin
            v = tab[i];
            rst = v.rst;
            bus.pll_locked = v.locked;
            exp_q.push_back(v);
            repeat (v.cycles) @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk({e.name, ".pll_reset"}, 32'(bus.pll_reset), 32'(e.pll));
            chk({e.name, ".rst_out"}, 32'(bus.rst_out), 32'(e.rsto));
            chk({e.name, ".ready"}, 32'(bus.ready), 32'(e.rdy));
            chk({e.name, ".retry_count"}, 32'(bus.retry_count), 32'(e.retry));
            chk({e.name, ".lock_loss_count"}, 32'(bus.lock_loss_count), 32'(e.loss));
        end

        // Async reset from RUN between edges: outputs clear before the next edge
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async.pll_reset", 32'(bus.pll_reset), 32'd1);
        chk("async.rst_out", 32'(bus.rst_out), 32'b111);
        chk("async.ready", 32'(bus.ready), 32'd0);
        chk("async.lock_loss_count", 32'(bus.lock_loss_count), 32'd0);
        chk("async.retry_count", 32'(bus.retry_count), 32'd0);
        bus.pll_locked = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // No lock ever: pll_reset rises every PRC+LT edges; retry_count saturates
        for (int k = 1; k <= 300; k++) rise_q.push_back(k * (PRC + LT));
        prev = bus.pll_reset;
        for (int c = 1; c <= 31300; c++) begin
            @(posedge clk); #1;
            if (bus.pll_reset && !prev) begin
                if (rise_q.size() == 0) chk("nl.extra_rise", 32'(c), 32'd0);
                else chk("nl.rise_cycle", 32'(c), 32'(rise_q.pop_front()));
            end
            prev = bus.pll_reset;
            if (c == 1000) begin
                chk("nl.retry_1000", 32'(bus.retry_count), 32'd9);
                chk("nl.rst_out_1000", 32'(bus.rst_out), 32'b111);
                chk("nl.ready_1000", 32'(bus.ready), 32'd0);
            end
            if (c == 26519) chk("sat.retry_254", 32'(bus.retry_count), 32'd254);
            if (c == 26520) chk("sat.retry_255", 32'(bus.retry_count), 32'd255);
        end
        chk("nl.rises_missing", 32'(rise_q.size()), 32'd0);
        chk("sat.retry_hold", 32'(bus.retry_count), 32'd255);
        chk("sat.lock_loss", 32'(bus.lock_loss_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
